mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL provide parameters: BUS_WIDTH, default 32, address/data width; STARVE_LIMIT, default 4, consecutive load/store grants allowed while fetch waits.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch read request.
- if_addr  in  BUS_WIDTH  fetch address.
- if_gnt  out  1  one-cycle pulse when the fetch request is accepted.
- if_rvalid  out  1  one-cycle pulse when if_rdata is valid.
- if_rdata  out  BUS_WIDTH  fetch read data.
- ls_req  in  1  load/store request.
- ls_wr  in  1  1 = store, 0 = load.
- ls_addr  in  BUS_WIDTH  load/store address.
- ls_wdata  in  BUS_WIDTH  store data.
- ls_gnt  out  1  one-cycle pulse when the load/store request is accepted.
- ls_rvalid  out  1  one-cycle pulse on load data or store completion.
- ls_rdata  out  BUS_WIDTH  load data.
- mem_req  out  1  memory request.
- mem_wr  out  1  memory write enable.
- mem_addr  out  BUS_WIDTH  memory address.
- mem_wdata  out  BUS_WIDTH  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  BUS_WIDTH  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 SHALL share one memory port between fetch and load/store using FSM states IDLE, ISSUE and WAIT_RD; all outputs SHALL be registered.
REQ-004 In IDLE, at the first edge where a request is present, the FSM SHALL latch owner, address, wr and wdata, pulse the owner's gnt in the following cycle, and move to ISSUE.
REQ-005 Selection SHALL use fixed priority: ls_req beats if_req when both are high.
REQ-006 In ISSUE, mem_req SHALL be held high with stable mem_addr, mem_wr and mem_wdata until mem_ready is sampled high.
REQ-007 On mem_ready with a write, the FSM SHALL pulse ls_rvalid in the next cycle and return to IDLE.
REQ-008 On mem_ready with a read, the FSM SHALL deassert mem_req and move to WAIT_RD.
REQ-009 In WAIT_RD, on mem_rvalid the FSM SHALL register mem_rdata into the owner's rdata, pulse that owner's rvalid for one cycle, and return to IDLE.
REQ-010 mem_rvalid outside WAIT_RD SHALL be ignored.
REQ-011 Minimum read latency SHALL be: req sampled at edge 0, mem_req high in cycle 1, mem_rvalid in cycle 2 gives rvalid in cycle 3.
REQ-012 A requester SHALL hold req, addr and data until its gnt; req still high after gnt is treated as a new request.
REQ-013 At most one transaction SHALL be outstanding; requests arriving while busy are held off with no gnt.
REQ-014 rdata SHALL hold its last value between rvalid pulses.

Reset
REQ-015 Asserting reset SHALL immediately force: state IDLE; all gnt, rvalid, mem_req, mem_wr and busy = 0; all address, data and rdata outputs = 0; starvation counter = 0.
REQ-016 Reset in mid-transaction SHALL abandon that transaction, and no rvalid SHALL be issued for it after reset releases.

Configuration
REQ-017 Macro ARB_STARVE_GUARD_EN, when defined, SHALL enable a starvation counter.
- The counter increments on each ls grant made while if_req is high.
- When the counter equals STARVE_LIMIT, the next selection SHALL go to fetch even if ls_req is high.
- The counter clears on any fetch grant or whenever if_req is low in IDLE.
- When the macro is undefined, there is no counter and fixed priority always applies.

Verification
REQ-018 Single fetch: if_req=1, if_addr=0x10, mem_ready=1 in cycle 1, mem_rvalid=1 with mem_rdata=0xDEADBEEF in cycle 2 -> if_gnt in cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 3.
REQ-019 Store with wait states: ls_wr=1, ls_addr=0x40, ls_wdata=0x5A, mem_ready low for 3 cycles -> mem_req, mem_addr=0x40 and mem_wdata=0x5A stay stable for 4 cycles, then a single ls_rvalid pulse.
REQ-020 Simultaneous requests: if_req and ls_req both rise in the same cycle -> ls served first, fetch granted in the first IDLE after it.
REQ-021 Starvation guard, with macro defined and STARVE_LIMIT=4: ls_req and if_req held high continuously -> grant order ls,ls,ls,ls,if,ls; with macro undefined -> ls only.
REQ-022 Reset during WAIT_RD: then mem_rvalid=1 after reset releases -> all outputs 0, no rvalid pulse, state IDLE.
REQ-023 Spurious mem_rvalid while in IDLE -> no rvalid and rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT back-to-back ls grants.
module mem_port_arbiter #(
    parameter int BUS_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [BUS_WIDTH-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [BUS_WIDTH-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_wr,
    input  logic [BUS_WIDTH-1:0] ls_addr,
    input  logic [BUS_WIDTH-1:0] ls_wdata,
    output logic                 ls_gnt,
    output logic                 ls_rvalid,
    output logic [BUS_WIDTH-1:0] ls_rdata,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic                 busy
);

    // state   | meaning
    // IDLE    | no transaction, selecting the next requester
    // ISSUE   | mem_req held with stable address/data until mem_ready
    // WAIT_RD | read accepted, waiting for mem_rvalid
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 owner_ls, owner_ls_nxt;
    logic                 pick_ls;
    logic                 if_gnt_nxt, ls_gnt_nxt;
    logic                 if_rvalid_nxt, ls_rvalid_nxt;
    logic [BUS_WIDTH-1:0] if_rdata_nxt, ls_rdata_nxt;
    logic                 mem_req_nxt, mem_wr_nxt;
    logic [BUS_WIDTH-1:0] mem_addr_nxt, mem_wdata_nxt;
    logic                 busy_nxt;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign pick_ls = ls_req && !(if_req && (starve_cnt == CNT_W'(STARVE_LIMIT)));

    // Counts ls grants taken while fetch waits; any other IDLE decision clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (if_req && pick_ls) starve_cnt <= starve_cnt + CNT_W'(1);
            else                   starve_cnt <= '0;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT > 0);
    assign pick_ls = ls_req;
`endif

    always_comb begin
        state_nxt     = state;
        owner_ls_nxt  = owner_ls;
        if_gnt_nxt    = 1'b0;
        ls_gnt_nxt    = 1'b0;
        if_rvalid_nxt = 1'b0;
        ls_rvalid_nxt = 1'b0;
        if_rdata_nxt  = if_rdata;
        ls_rdata_nxt  = ls_rdata;
        mem_req_nxt   = mem_req;
        mem_wr_nxt    = mem_wr;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        case (state)
            IDLE: begin
                if (pick_ls) begin
                    owner_ls_nxt  = 1'b1;
                    ls_gnt_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_wr_nxt    = ls_wr;
                    mem_addr_nxt  = ls_addr;
                    mem_wdata_nxt = ls_wdata;
                    state_nxt     = ISSUE;
                end else if (if_req) begin
                    owner_ls_nxt  = 1'b0;
                    if_gnt_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_wr_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_req_nxt = 1'b0;
                    mem_wr_nxt  = 1'b0;
                    if (mem_wr) begin
                        ls_rvalid_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        state_nxt = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    if (owner_ls) begin
                        ls_rdata_nxt  = mem_rdata;
                        ls_rvalid_nxt = 1'b1;
                    end else begin
                        if_rdata_nxt  = mem_rdata;
                        if_rvalid_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_ls  <= 1'b0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner_ls  <= owner_ls_nxt;
            if_gnt    <= if_gnt_nxt;
            ls_gnt    <= ls_gnt_nxt;
            if_rvalid <= if_rvalid_nxt;
            ls_rvalid <= ls_rvalid_nxt;
            if_rdata  <= if_rdata_nxt;
            ls_rdata  <= ls_rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// transaction-level reference model with a behavioural memory.
module tb_mem_port_arbiter;
    localparam int BW    = 32;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, ls_req, ls_wr, mem_ready, mem_rvalid;
    logic [BW-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy;
    logic [BW-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [BW-1:0] exp_if_rdata, exp_ls_rdata;
    logic [BW-1:0] mem_model [logic [BW-1:0]];

    mem_port_arbiter #(.BUS_WIDTH(BW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 0; ls_req = 0; ls_wr = 0; mem_ready = 0; mem_rvalid = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    endtask

    function automatic logic [BW-1:0] mem_read(input logic [BW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], 16'hBEEF};
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick(); tick();
        n_tests++;
        if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy});
        end
        n_tests++;
        if ({if_rdata, ls_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {if_rdata, ls_rdata, mem_addr, mem_wdata});
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({if_gnt, ls_gnt, mem_req, busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_release_idle: got %b expected 0", {if_gnt, ls_gnt, mem_req, busy});
        end
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h10;
        tick();
        n_tests++;
        if ({if_gnt, ls_gnt, mem_req, mem_wr, busy} !== 5'b10101 || mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL fetch_issue: got gnt/req %b addr %h expected 10101 addr 10", {if_gnt, ls_gnt, mem_req, mem_wr, busy}, mem_addr);
        end
        if_req = 0; mem_ready = 1;
        tick();
        n_tests++;
        if ({if_gnt, mem_req, busy, if_rvalid} !== 4'b0010) begin
            n_fail++; $display("FAIL fetch_wait_rd: got %b expected 0010", {if_gnt, mem_req, busy, if_rvalid});
        end
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        n_tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || ls_rvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fetch_rvalid: got rv %b data %h busy %b expected 1 deadbeef 0", if_rvalid, if_rdata, busy);
        end
        exp_if_rdata = 32'hDEADBEEF;
        tick();
        n_tests++;
        if (if_rvalid !== 1'b0 || if_rdata !== exp_if_rdata) begin
            n_fail++; $display("FAIL fetch_rdata_hold: got rv %b data %h expected 0 %h", if_rvalid, if_rdata, exp_if_rdata);
        end
    endtask

    task automatic test_store_wait();
        ls_req = 1; ls_wr = 1; ls_addr = 32'h40; ls_wdata = 32'h5A;
        tick();
        n_tests++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            n_fail++; $display("FAIL store_gnt: got ls %b if %b expected 1 0", ls_gnt, if_gnt);
        end
        ls_req = 0; ls_wr = 0; ls_addr = '0; ls_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({mem_req, mem_wr} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'h5A || ls_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL store_stable[%0d]: got req/wr %b addr %h wdata %h expected 11 40 5a", i, {mem_req, mem_wr}, mem_addr, mem_wdata);
            end
            if (i == 3) mem_ready = 1;
            tick();
        end
        mem_ready = 0;
        mem_model[32'h40] = 32'h5A;
        n_tests++;
        if (ls_rvalid !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || ls_rdata !== exp_ls_rdata) begin
            n_fail++; $display("FAIL store_done: got rv %b req %b busy %b rdata %h expected 1 0 0 %h", ls_rvalid, mem_req, busy, ls_rdata, exp_ls_rdata);
        end
        tick();
        n_tests++;
        if (ls_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL store_single_pulse: got %b expected 0", ls_rvalid);
        end
    endtask

    task automatic test_simultaneous();
        if_req = 1; if_addr = 32'h80;
        ls_req = 1; ls_wr = 1; ls_addr = 32'h44; ls_wdata = 32'h1234;
        tick();
        n_tests++;
        if ({ls_gnt, if_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL simul_first: got ls/if gnt %b expected 10", {ls_gnt, if_gnt});
        end
        ls_req = 0; ls_wr = 0; mem_ready = 1;
        tick();
        mem_ready = 0;
        mem_model[32'h44] = 32'h1234;
        n_tests++;
        if ({ls_rvalid, if_gnt, busy} !== 3'b100) begin
            n_fail++; $display("FAIL simul_ls_done: got %b expected 100", {ls_rvalid, if_gnt, busy});
        end
        tick();
        n_tests++;
        if ({if_gnt, ls_gnt} !== 2'b10 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL simul_if_gnt: got %b addr %h expected 10 addr 80", {if_gnt, ls_gnt}, mem_addr);
        end
        if_req = 0; mem_ready = 1;
        tick();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hA1B2C3D4;
        tick();
        mem_rvalid = 0;
        n_tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hA1B2C3D4 || ls_rdata !== exp_ls_rdata) begin
            n_fail++; $display("FAIL simul_if_data: got %b %h expected 1 a1b2c3d4", if_rvalid, if_rdata);
        end
        exp_if_rdata = 32'hA1B2C3D4;
    endtask

    task automatic test_spurious_rvalid();
        mem_rvalid = 1; mem_rdata = $urandom();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({if_rvalid, ls_rvalid, busy} !== 3'b000 || if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
                n_fail++; $display("FAIL spurious_rvalid[%0d]: got %b %h %h expected 000 %h %h", i, {if_rvalid, ls_rvalid, busy}, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
            end
        end
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_starvation();
        bit exp_ls [6];
        bit got_ls [6];
        int ng  = 0;
        int cnt = 0;
        drive_idle();
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            exp_ls[k] = !(GUARD && cnt == LIMIT);
            cnt = exp_ls[k] ? cnt + 1 : 0;
        end
        if_req = 1; if_addr = 32'hC; ls_req = 1; ls_wr = 1; ls_addr = 32'h8; ls_wdata = 32'h77;
        mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h55;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            tick();
            if (ls_gnt || if_gnt) begin
                got_ls[ng] = ls_gnt;
                ng++;
            end
        end
        drive_idle();
        n_tests++;
        if (ng !== 6) begin
            n_fail++; $display("FAIL starve_timeout: got %0d grants expected 6", ng);
        end
        for (int k = 0; k < ng; k++) begin
            n_tests++;
            if (got_ls[k] !== exp_ls[k]) begin
                n_fail++; $display("FAIL starve_order[%0d]: got ls=%0d expected ls=%0d", k, got_ls[k], exp_ls[k]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        drive_idle();
        pulse_reset();
        if_req = 1; if_addr = 32'h20;
        tick();
        if_req = 0; mem_ready = 1;
        tick();
        mem_ready = 0;
        n_tests++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_in_wait: got busy %b req %b expected 1 0", busy, mem_req);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy} !== 7'b0 || {if_rdata, ls_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL rstmid_async: got %b %h expected all 0", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy}, {if_rdata, mem_addr});
        end
        tick();
        reset = 1'b0;
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy} !== 7'b0 || {if_rdata, ls_rdata, mem_addr, mem_wdata} !== '0) begin
                n_fail++; $display("FAIL rstmid_after[%0d]: got %b rdata %h expected all 0", i, {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wr, busy}, if_rdata);
            end
        end
        drive_idle();
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    task automatic test_random_traffic();
        bit if_pend = 0, ls_pend = 0, win_ls, is_wr;
        int cnt = 0;
        logic [BW-1:0] exp_addr, exp_wdata, rd;
        drive_idle();
        pulse_reset();
        mem_model.delete();
        for (int t = 0; t < 60; t++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1; if_addr = BW'($urandom_range(0, 15)) << 2;
            end
            if (!ls_pend && ($urandom_range(0, 1) == 1 || !if_pend)) begin
                ls_pend = 1; ls_wr = $urandom_range(0, 1) == 1;
                ls_addr = BW'($urandom_range(0, 15)) << 2; ls_wdata = $urandom();
            end
            if_req = if_pend; ls_req = ls_pend;
            win_ls    = ls_pend && !(GUARD && if_pend && cnt == LIMIT);
            cnt       = (win_ls && if_pend) ? cnt + 1 : 0;
            is_wr     = win_ls && ls_wr;
            exp_addr  = win_ls ? ls_addr : if_addr;
            exp_wdata = ls_wdata;
            tick();
            n_tests++;
            if ({ls_gnt, if_gnt} !== {win_ls, !win_ls} || mem_req !== 1'b1 || mem_addr !== exp_addr || mem_wr !== is_wr || (is_wr && mem_wdata !== exp_wdata)) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got ls/if %b addr %h wr %b expected %b addr %h wr %b", t, {ls_gnt, if_gnt}, mem_addr, mem_wr, {win_ls, !win_ls}, exp_addr, is_wr);
            end
            if (win_ls) begin ls_pend = 0; ls_req = 0; end
            else        begin if_pend = 0; if_req = 0; end
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                mem_rvalid = $urandom_range(0, 1) == 1; mem_rdata = $urandom();
                tick();
                n_tests++;
                if ({mem_req, ls_gnt, if_gnt, ls_rvalid, if_rvalid} !== 5'b10000 || mem_addr !== exp_addr) begin
                    n_fail++; $display("FAIL rand_issue_hold[%0d]: got %b addr %h expected 10000 addr %h", t, {mem_req, ls_gnt, if_gnt, ls_rvalid, if_rvalid}, mem_addr, exp_addr);
                end
            end
            mem_rvalid = 0; mem_ready = 1;
            tick();
            mem_ready = 0;
            if (is_wr) begin
                mem_model[exp_addr] = exp_wdata;
                n_tests++;
                if ({ls_rvalid, if_rvalid, mem_req, busy, ls_gnt, if_gnt} !== 6'b100000 || ls_rdata !== exp_ls_rdata) begin
                    n_fail++; $display("FAIL rand_store_done[%0d]: got %b rdata %h expected 100000 %h", t, {ls_rvalid, if_rvalid, mem_req, busy, ls_gnt, if_gnt}, ls_rdata, exp_ls_rdata);
                end
            end else begin
                for (int w = $urandom_range(0, 3); w >= 0; w--) begin
                    n_tests++;
                    if ({mem_req, busy, ls_rvalid, if_rvalid, ls_gnt, if_gnt} !== 6'b010000) begin
                        n_fail++; $display("FAIL rand_wait_rd[%0d]: got %b expected 010000", t, {mem_req, busy, ls_rvalid, if_rvalid, ls_gnt, if_gnt});
                    end
                    if (w == 0) begin
                        rd = mem_read(exp_addr);
                        mem_rvalid = 1; mem_rdata = rd;
                    end
                    tick();
                end
                mem_rvalid = 0; mem_rdata = $urandom();
                if (win_ls) exp_ls_rdata = rd;
                else        exp_if_rdata = rd;
                n_tests++;
                if ({ls_rvalid, if_rvalid} !== {win_ls, !win_ls} || busy !== 1'b0 || ls_rdata !== exp_ls_rdata || if_rdata !== exp_if_rdata) begin
                    n_fail++; $display("FAIL rand_read_done[%0d]: got rv %b ls %h if %h expected %b ls %h if %h", t, {ls_rvalid, if_rvalid}, ls_rdata, if_rdata, {win_ls, !win_ls}, exp_ls_rdata, exp_if_rdata);
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_simultaneous();
        test_spurious_rvalid();
        test_starvation();
        test_reset_mid_read();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
